plru_ctrl: RTL and testbench

- Sequences the dual-port LRU state array of a set-associative cache using a 4-way tree pseudo-LRU policy.
- Accepts one lookup per cycle from the cache controller and reads that set's PLRU bits on array port 0. It returns the victim way and writes the updated bits back on array port 1.
- Also runs a sweep of all sets back to 0 on request (flush/init).
- Sits between the cache control FSM and the lru_array instance.

---
 rtl/cache_pkg.sv | 17 +
 rtl/plru_ctrl_if.sv | 26 ++
 rtl/plru_tree_logic.sv | 27 ++
 rtl/plru_ctrl.sv | 135 +++++++++++++
 tb/tb_plru_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache types: PLRU tree bit positions, controller FSM states and the way index type.
package cache_pkg;

    localparam int ROOT  = 0;
    localparam int LEFT  = 1;
    localparam int RIGHT = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        INIT  = 2'd2,
        DONE  = 2'd3
    } plru_state_t;

    typedef logic [1:0] way_t;

endpackage

// File: rtl/plru_ctrl_if.sv
// Lookup request/response channel between the cache control FSM and plru_ctrl.
interface plru_ctrl_if #(
    parameter int S_INDEX = 4
);
    import cache_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [S_INDEX-1:0] req_set;
    logic               req_hit;
    way_t               req_way;
    logic               resp_valid;
    logic [S_INDEX-1:0] resp_set;
    way_t               resp_way;

    modport master (
        output req_valid, req_set, req_hit, req_way,
        input  req_ready, resp_valid, resp_set, resp_way
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_way,
        output req_ready, resp_valid, resp_set, resp_way
    );

endinterface

// File: rtl/plru_tree_logic.sv
// 4-way tree pseudo-LRU: victim selection and the update that points the tree away from the touched way.
module plru_tree_logic
    import cache_pkg::*;
(
    input  logic [2:0] bits,
    input  logic       hit,
    input  way_t       way,
    output way_t       victim,
    output way_t       touched,
    output logic [2:0] new_bits
);

    // Root picks the half, the pair bit picks the way inside that half.
    always_comb begin
        victim   = bits[ROOT] ? (bits[RIGHT] ? 2'd3 : 2'd2)
                              : (bits[LEFT]  ? 2'd1 : 2'd0);
        touched  = hit ? way : victim;
        new_bits = bits;
        new_bits[ROOT] = ~touched[1];
        if (touched[1]) begin
            new_bits[RIGHT] = ~touched[0];
        end else begin
            new_bits[LEFT]  = ~touched[0];
        end
    end

endmodule

// File: rtl/plru_ctrl.sv
// plru_ctrl: sequences a dual-port PLRU state array; reads on port 0, writes updated bits on port 1,
// and sweeps every set back to zero on init_start.
module plru_ctrl
    import cache_pkg::*;
#(
    parameter int S_INDEX = 4,
    parameter int WAYS    = 4,
    parameter int WIDTH   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    plru_ctrl_if.slave         bus,
    input  logic               init_start,
    output logic               init_busy,
    output logic               init_done,
    output logic               lru_csb0,
    output logic               lru_web0,
    output logic [S_INDEX-1:0] lru_addr0,
    output logic [WIDTH-1:0]   lru_din0,
    input  logic [WIDTH-1:0]   lru_dout0,
    output logic               lru_csb1,
    output logic               lru_web1,
    output logic [S_INDEX-1:0] lru_addr1,
    output logic [WIDTH-1:0]   lru_din1
);

    localparam int               WAY_W    = $clog2(WAYS);
    localparam int               NUM_SETS = 2 ** S_INDEX;
    localparam logic [S_INDEX:0] LAST_SET = (S_INDEX + 1)'(NUM_SETS - 1);

    plru_state_t        state;
    logic [S_INDEX:0]   ptr;
    logic               ready_q;
    logic               s1_valid;
    logic [S_INDEX-1:0] s1_set;
    logic               s1_hit;
    logic [WAY_W-1:0]   s1_way;
    logic               accept;
    logic [WAY_W-1:0]   victim;
    logic [WAY_W-1:0]   touched;
    logic [WIDTH-1:0]   new_bits;

    assign accept        = bus.req_valid & ready_q;
    assign bus.req_ready = ready_q;

    // Any request in flight (already in stage 1 or accepted this cycle) must write back before the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ptr       <= '0;
            ready_q   <= 1'b1;
            init_busy <= 1'b0;
            init_done <= 1'b0;
            s1_valid  <= 1'b0;
            s1_set    <= '0;
            s1_hit    <= 1'b0;
            s1_way    <= '0;
        end else begin
            s1_valid  <= accept;
            init_done <= 1'b0;
            if (accept) begin
                s1_set <= bus.req_set;
                s1_hit <= bus.req_hit;
                s1_way <= bus.req_way;
            end
            case (state)
                RUN: begin
                    if (init_start) begin
                        ready_q   <= 1'b0;
                        init_busy <= 1'b1;
                        ptr       <= '0;
                        state     <= (s1_valid || accept) ? DRAIN : INIT;
                    end
                end
                DRAIN: begin
                    state <= INIT;
                end
                INIT: begin
                    if (ptr == LAST_SET) begin
                        state     <= DONE;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    state   <= RUN;
                    ready_q <= 1'b1;
                    ptr     <= '0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    plru_tree_logic u_tree (
        .bits     (lru_dout0),
        .hit      (s1_hit),
        .way      (s1_way),
        .victim   (victim),
        .touched  (touched),
        .new_bits (new_bits)
    );

    assign lru_csb0  = ~accept;
    assign lru_web0  = 1'b1;
    assign lru_addr0 = accept ? bus.req_set : '0;
    assign lru_din0  = '0;

    assign bus.resp_valid = s1_valid;
    assign bus.resp_set   = s1_set;
    assign bus.resp_way   = !s1_valid ? '0 : (s1_hit ? touched : victim);

    // Port 1 belongs to the sweep during INIT, otherwise to the stage-1 write-back.
    always_comb begin
        lru_csb1  = 1'b1;
        lru_web1  = 1'b1;
        lru_addr1 = '0;
        lru_din1  = '0;
        if (state == INIT) begin
            lru_csb1  = 1'b0;
            lru_web1  = 1'b0;
            lru_addr1 = ptr[S_INDEX-1:0];
        end else if (s1_valid) begin
            lru_csb1  = 1'b0;
            lru_web1  = 1'b0;
            lru_addr1 = s1_set;
            lru_din1  = new_bits;
        end
    end

endmodule

// File: tb/tb_plru_ctrl.sv
// Scoreboard bench for plru_ctrl: a behavioural PLRU model per set, a dual-port array with forwarding,
// directed scenarios, a random hit/miss stream and reset-during-sweep checks.
module tb_plru_ctrl;

    typedef struct {
        int set;
        int way;
        int bits;
        int due;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       init_start;
    logic       init_busy;
    logic       init_done;
    logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
    logic [3:0] lru_addr0, lru_addr1;
    logic [2:0] lru_din0, lru_din1, lru_dout0;
    logic       arr_clear;

    logic [2:0] mem [16];
    bit   [2:0] mdl [16];
    exp_t       expq [$];
    int         cyc;
    int         n_checks;
    int         n_fail;

    plru_ctrl_if #(.S_INDEX(4)) bus ();

    plru_ctrl #(.S_INDEX(4), .WAYS(4), .WIDTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .lru_csb0   (lru_csb0),
        .lru_web0   (lru_web0),
        .lru_addr0  (lru_addr0),
        .lru_din0   (lru_din0),
        .lru_dout0  (lru_dout0),
        .lru_csb1   (lru_csb1),
        .lru_web1   (lru_web1),
        .lru_addr1  (lru_addr1),
        .lru_din1   (lru_din1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Array model: port-1 write in the same cycle as a port-0 read of that set is forwarded.
    always @(posedge clk) begin
        if (arr_clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 3'b000;
            lru_dout0 <= 3'b000;
        end else begin
            if (!lru_csb0)
                lru_dout0 <= (!lru_csb1 && !lru_web1 && lru_addr1 == lru_addr0) ? lru_din1 : mem[lru_addr0];
            if (!lru_csb1 && !lru_web1)
                mem[lru_addr1] <= lru_din1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference PLRU: victim half from the root, way inside the half from that pair's bit.
    function automatic void pushExpect(input int s, input int h, input int w);
        exp_t e;
        int b0, b1, b2, tw;
        b0 = int'(mdl[s][0]);
        b1 = int'(mdl[s][1]);
        b2 = int'(mdl[s][2]);
        if (h != 0) tw = w;
        else        tw = 2 * b0 + ((b0 != 0) ? b2 : b1);
        if (tw < 2) begin
            b0 = 1;
            b1 = (tw == 0) ? 1 : 0;
        end else begin
            b0 = 0;
            b2 = (tw == 2) ? 1 : 0;
        end
        mdl[s] = 3'(b2 * 4 + b1 * 2 + b0);
        e.set  = s;
        e.way  = tw;
        e.bits = b2 * 4 + b1 * 2 + b0;
        e.due  = cyc + 1;
        expq.push_back(e);
    endfunction

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic applyStimulus(input int v, input int s, input int h, input int w, input int ini);
        bus.req_valid = (v != 0);
        bus.req_set   = 4'(s);
        bus.req_hit   = (h != 0);
        bus.req_way   = 2'(w);
        init_start    = (ini != 0);
        @(negedge clk);
        if (v != 0 && bus.req_ready) pushExpect(s, h, w);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        init_start    = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " lru_csb0"},   int'(lru_csb0), 1);
        checkOutput({tag, " lru_web0"},   int'(lru_web0), 1);
        checkOutput({tag, " lru_csb1"},   int'(lru_csb1), 1);
        checkOutput({tag, " lru_web1"},   int'(lru_web1), 1);
        checkOutput({tag, " lru_addr0"},  int'(lru_addr0), 0);
        checkOutput({tag, " lru_addr1"},  int'(lru_addr1), 0);
        checkOutput({tag, " lru_din0"},   int'(lru_din0), 0);
        checkOutput({tag, " lru_din1"},   int'(lru_din1), 0);
        checkOutput({tag, " resp_valid"}, int'(bus.resp_valid), 0);
        checkOutput({tag, " init_busy"},  int'(init_busy), 0);
        checkOutput({tag, " init_done"},  int'(init_done), 0);
        checkOutput({tag, " req_ready"},  int'(bus.req_ready), 1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drained", expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response must match the oldest expectation, one cycle after acceptance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.resp_valid) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected resp: got set %0d way %0d, expected no response",
                             bus.resp_set, bus.resp_way);
                end else begin
                    e = expq.pop_front();
                    checkOutput("resp latency", cyc, e.due);
                    checkOutput("resp_set", int'(bus.resp_set), e.set);
                    checkOutput("resp_way", int'(bus.resp_way), e.way);
                    checkOutput("wb lru_csb1", int'(lru_csb1), 0);
                    checkOutput("wb lru_web1", int'(lru_web1), 0);
                    checkOutput("wb lru_addr1", int'(lru_addr1), e.set);
                    checkOutput("wb lru_din1", int'(lru_din1), e.bits);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nreq;
        cyc           = 0;
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        arr_clear     = 1'b1;
        init_start    = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_set   = '0;
        bus.req_hit   = 1'b0;
        bus.req_way   = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 3'b000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        arr_clear = 1'b0;

        $display("[TB] two misses on set 5 with a gap");
        applyStimulus(1, 5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0);
        waitDrain();

        $display("[TB] back-to-back misses on set 3");
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0);
        waitDrain();

        $display("[TB] hit set 7 way 3 then miss set 7");
        applyStimulus(1, 7, 1, 3, 0);
        applyStimulus(1, 7, 0, 0, 0);
        waitDrain();

        $display("[TB] request with simultaneous init_start");
        applyStimulus(1, 1, 0, 0, 1);
        @(negedge clk);
        checkOutput("drain req_ready", int'(bus.req_ready), 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("init lru_csb1", int'(lru_csb1), 0);
            checkOutput("init lru_web1", int'(lru_web1), 0);
            checkOutput("init lru_addr1", int'(lru_addr1), i);
            checkOutput("init lru_din1", int'(lru_din1), 0);
            checkOutput("init req_ready", int'(bus.req_ready), 0);
            checkOutput("init init_busy", int'(init_busy), 1);
            checkOutput("init init_done", int'(init_done), 0);
        end
        @(negedge clk);
        checkOutput("done init_done", int'(init_done), 1);
        checkOutput("done init_busy", int'(init_busy), 0);
        checkOutput("done lru_csb1", int'(lru_csb1), 1);
        @(negedge clk);
        checkOutput("after done init_done", int'(init_done), 0);
        checkOutput("after done req_ready", int'(bus.req_ready), 1);
        for (int i = 0; i < 16; i++) mdl[i] = 3'b000;
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 0, 0, 0);
        waitDrain();

        $display("[TB] random hit/miss stream");
        nreq = 0;
        while (nreq < 10000) begin
            if ($urandom_range(0, 9) < 8) begin
                applyStimulus(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                              int'($urandom_range(0, 3)), 0);
                nreq++;
            end else begin
                applyStimulus(0, 0, 0, 0, 0);
            end
        end
        waitDrain();

        $display("[TB] reset during the eighth sweep cycle");
        applyStimulus(0, 0, 0, 0, 1);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("pre-reset lru_addr1", int'(lru_addr1), 7);
        checkOutput("pre-reset lru_csb1", int'(lru_csb1), 0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-init reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("post-reset req_ready", int'(bus.req_ready), 1);
            checkOutput("post-reset lru_csb1", int'(lru_csb1), 1);
            checkOutput("post-reset init_busy", int'(init_busy), 0);
            checkOutput("post-reset resp_valid", int'(bus.resp_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
